// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 master/slave bus bundle used by the burst master.
interface wb_b3_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic [1:0]    wb_bte_o;
    logic [2:0]    wb_cti_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: runs one 1..16 beat read or write burst per command,
// with linear or wrapping addressing, err/rty abort and a stall watchdog.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready_o high
// BUS   | cycle open, beats issued until the last ack or an abort
// DONE  | one-cycle completion pulse with error flag and beat count
module wb_b3_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          done_o,
    output logic          done_err_o,
    output logic [4:0]    done_beats_o,
    wb_b3_burst_master_if.master wb
);

    // one spare count so a watchdog of TIMEOUT cycles always fits
    localparam int WDW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state, state_nxt;
    logic          we_q;
    logic [3:0]    len_q;
    logic [1:0]    bte_q;
    logic [AW-1:0] adr_q;
    logic [2:0]    cti_q;
    logic [4:0]    beat_q;
    logic [WDW-1:0] wd_q;

    logic          in_bus;
    logic          stb;
    logic          term;
    logic          beat_ok;
    logic          stall;
    logic          wd_expire;
    logic          abort;
    logic          last_beat;
    logic          accept;
    logic [3:0]    wrap_inc;
    logic [3:0]    wrap_mask;
    logic [AW-1:0] adr_nxt;

    assign in_bus    = (state == BUS);
    assign stb       = in_bus & (~we_q | wr_valid_i);
    // err and rty both terminate the cycle and take priority over ack
    assign term      = wb.wb_err_i | wb.wb_rty_i;
    assign beat_ok   = stb & wb.wb_ack_i & ~term;
    assign stall     = stb & ~wb.wb_ack_i & ~term;
    assign wd_expire = (TIMEOUT != 0) && stall && ((wd_q + WDW'(1)) == WDW'(TIMEOUT));
    assign abort     = (stb & term) | wd_expire;
    assign last_beat = beat_ok & (beat_q == {1'b0, len_q});
    assign accept    = cmd_valid_i & (state == IDLE);

    // wrapping bursts only rotate the low word-index bits inside the wrap block
    always_comb begin
        wrap_mask = 4'b1111;
        case (bte_q)
            2'b01:   wrap_mask = 4'b0011;
            2'b10:   wrap_mask = 4'b0111;
            default: wrap_mask = 4'b1111;
        endcase
        wrap_inc = adr_q[5:2] + 4'd1;
        adr_nxt  = adr_q + AW'(4);
        if (bte_q != 2'b00) begin
            adr_nxt = {adr_q[AW-1:6], (adr_q[5:2] & ~wrap_mask) | (wrap_inc & wrap_mask), 2'b00};
        end
    end

    // state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= IDLE;
        else           state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = BUS;
            BUS:     if (abort || last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // burst context, address/cti sequencing, watchdog and completion status
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            we_q         <= 1'b0;
            len_q        <= '0;
            bte_q        <= '0;
            adr_q        <= '0;
            cti_q        <= '0;
            beat_q       <= '0;
            wd_q         <= '0;
            rd_valid_o   <= 1'b0;
            rd_data_o    <= '0;
            done_err_o   <= 1'b0;
            done_beats_o <= '0;
        end else begin
            rd_valid_o <= beat_ok & ~we_q;
            if (accept) begin
                we_q   <= cmd_we_i;
                len_q  <= cmd_len_i;
                bte_q  <= cmd_bte_i;
                adr_q  <= cmd_adr_i & ~AW'(3);
                cti_q  <= (cmd_len_i == 4'd0) ? 3'b000 : 3'b010;
                beat_q <= '0;
                wd_q   <= '0;
            end else if (beat_ok) begin
                beat_q <= beat_q + 5'd1;
                wd_q   <= '0;
                adr_q  <= adr_nxt;
                if (!we_q) rd_data_o <= wb.wb_dat_i;
                // the next beat is the final one: announce end-of-burst
                if (len_q != 4'd0 && beat_q == ({1'b0, len_q} - 5'd1)) cti_q <= 3'b111;
            end else if (stall && TIMEOUT != 0) begin
                wd_q <= wd_q + WDW'(1);
            end
            if (in_bus && (abort || last_beat)) begin
                done_err_o   <= abort;
                done_beats_o <= last_beat ? beat_q + 5'd1 : beat_q;
            end
        end
    end

    assign cmd_ready_o = (state == IDLE);
    assign done_o      = (state == DONE);
    assign wr_ready_o  = stb & we_q & wb.wb_ack_i & ~term;

    assign wb.wb_cyc_o = in_bus;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_bte_o = bte_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_sel_o = {4{in_bus}};
    assign wb.wb_dat_o = wr_data_i;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Randomised scoreboard bench for wb_b3_burst_master with a behavioural slave.
module tb_wb_b3_burst_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [1:0]  bte;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic       err;
        logic [4:0] beats;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, done_err;
    logic [4:0]  done_beats;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    done_t       exp_done[$];

    wb_b3_burst_master_if #(.AW(AW), .DW(DW)) wb ();

    wb_b3_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_len_i   (cmd_len),
        .cmd_bte_i   (cmd_bte),
        .wr_data_i   (wr_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .done_o      (done),
        .done_err_o  (done_err),
        .done_beats_o(done_beats),
        .wb          (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference addressing: linear +4 modulo 2^32, or wrap inside a 16/32/64-byte block.
    function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
        longint unsigned blk, base;
        if (bte == 2'd0) return a + 32'd4;
        blk  = longint'(8) << bte;
        base = longint'(a) - (longint'(a) % blk);
        return 32'(base + ((longint'(a) - base + 4) % blk));
    endfunction

    function automatic logic [2:0] exp_cti(input int i, input int len);
        if (len == 0) return 3'b000;
        return (i == len) ? 3'b111 : 3'b010;
    endfunction

    // One burst: push expectations, issue the command, then play the slave until done_o.
    task automatic run_cmd(input bit we, input logic [31:0] adr, input int len, input int bte,
                           input bit rnd, input int err_beat, input bit use_rty, input bit noack,
                           input int gap_beat, input int gap_len);
        logic [31:0] a;
        logic [31:0] wdat[16];
        beat_t b;
        done_t d;
        int n_exp, beats, stall, stb_hi, stb_lo, wrr, gap_left, cyc;
        bit gap_done;
        beats = 0; stall = 0; stb_hi = 0; stb_lo = 0; wrr = 0; gap_left = 0; gap_done = 0;
        n_exp = noack ? 0 : ((err_beat >= 0) ? err_beat : len + 1);
        a = adr & ~32'h3;
        for (int i = 0; i <= len; i++) begin
            wdat[i] = $urandom;
            if (i < n_exp) begin
                b.adr = a; b.cti = exp_cti(i, len); b.we = we; b.bte = 2'(bte); b.dat = wdat[i];
                exp_beats.push_back(b);
            end
            a = next_adr(a, 2'(bte));
        end
        d.err = noack || (err_beat >= 0);
        d.beats = 5'(n_exp);
        exp_done.push_back(d);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 4'(len); cmd_bte = 2'(bte);
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
        #1 chk("cmd_ready_idle", cmd_ready, 1);

        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (done) break;
            cmd_valid = rnd ? 1'($urandom % 2) : 1'b0;
            cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_len = 4'($urandom); cmd_bte = 2'($urandom);
            if (!gap_done && we && beats == gap_beat) begin
                gap_left = gap_len; gap_done = 1'b1;
            end
            if (we) wr_valid = (gap_left == 0) && (!rnd || ($urandom % 4 != 0));
            else    wr_valid = 1'($urandom % 2);
            if (gap_left > 0) gap_left--;
            wr_data = wdat[(beats > 15) ? 15 : beats];
            wb.wb_ack_i = noack ? 1'b0 : (!rnd || stall >= 3 || ($urandom % 2 == 1));
            wb.wb_err_i = 1'b0;
            wb.wb_rty_i = 1'b0;
            if (beats == err_beat) begin
                if (use_rty) wb.wb_rty_i = 1'b1;
                else         wb.wb_err_i = 1'b1;
            end
            wb.wb_dat_i = $urandom;
            #1;
            if (wb.wb_stb_o) begin
                stb_hi++;
                if (!(wb.wb_err_i || wb.wb_rty_i)) begin
                    if (wb.wb_ack_i) begin beats++; stall = 0; end
                    else stall++;
                end
            end else if (wb.wb_cyc_o) begin
                stb_lo++;
            end
            if (wr_ready) wrr++;
        end
        chk("done_seen", done, 1);
        cmd_valid = 1'b0; wr_valid = 1'b0;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
        if (we) chk("wr_ready_pulses", wrr, n_exp);
        if (noack) chk("watchdog_stb_cycles", stb_hi, TO);
        if (!rnd && we && gap_len > 0) chk("stb_low_cycles", stb_lo, gap_len);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("done_beats_hold", done_beats, n_exp);
        chk("done_err_hold", done_err, d.err);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    // Monitor: compares every observable DUT output against the queued expectations.
    initial begin
        beat_t mb;
        done_t md;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (rd_valid) begin
                    chk("rd_expected_pending", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
                end
                if (wb.wb_cyc_o && exp_beats.size() > 0) begin
                    mb = exp_beats[0];
                    chk("bus_adr", wb.wb_adr_o, mb.adr);
                    chk("bus_cti", wb.wb_cti_o, mb.cti);
                    chk("bus_we", wb.wb_we_o, mb.we);
                    chk("bus_bte", wb.wb_bte_o, mb.bte);
                    chk("bus_sel", wb.wb_sel_o, 4'hf);
                end
                if (!wb.wb_cyc_o) chk("stb_without_cyc", wb.wb_stb_o, 0);
                if (wb.wb_cyc_o && wb.wb_we_o && !wr_valid) chk("stb_wait_state", wb.wb_stb_o, 0);
                if (wb.wb_stb_o && wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i) begin
                    chk("beat_expected_pending", exp_beats.size() > 0, 1);
                    if (exp_beats.size() > 0) begin
                        mb = exp_beats.pop_front();
                        if (mb.we) begin
                            chk("wr_dat", wb.wb_dat_o, mb.dat);
                            chk("wr_ready_beat", wr_ready, 1);
                        end else begin
                            exp_rd.push_back(wb.wb_dat_i);
                            chk("wr_ready_read", wr_ready, 0);
                        end
                    end
                end else begin
                    chk("wr_ready_idle", wr_ready, 0);
                end
                if (done) begin
                    chk("done_cyc_low", wb.wb_cyc_o, 0);
                    chk("done_expected_pending", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        md = exp_done.pop_front();
                        chk("done_err", done_err, md.err);
                        chk("done_beats", done_beats, md.beats);
                    end
                    chk("beats_left_at_done", exp_beats.size(), 0);
                end
            end
        end
    end

    initial begin
        int beats;
        int len, err_beat;
        bit we, noack;
        logic [31:0] adr;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wb.wb_dat_i = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", wb.wb_cyc_o, 0);
        chk("rst_stb", wb.wb_stb_o, 0);
        chk("rst_adr", wb.wb_adr_o, 0);
        chk("rst_cti", wb.wb_cti_o, 0);
        chk("rst_done", done, 0);
        chk("rst_done_beats", done_beats, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_cmd(0, 32'h0000_0100, 3, 0, 0, -1, 0, 0, -1, 0);
        run_cmd(1, 32'h0000_001C, 7, 2, 0, -1, 0, 0, 3, 2);
        run_cmd(0, 32'h0000_0040, 0, 0, 0, -1, 0, 0, -1, 0);
        run_cmd(0, 32'h0000_0300, 15, 0, 0, 5, 0, 0, -1, 0);
        run_cmd(0, 32'h0000_0080, 3, 0, 0, -1, 0, 1, -1, 0);
        run_cmd(0, 32'hFFFF_FFF8, 3, 0, 0, -1, 0, 0, -1, 0);
        run_cmd(1, 32'h0000_0500, 4, 1, 0, 2, 1, 0, -1, 0);
        run_cmd(0, 32'h0000_013C, 15, 3, 0, -1, 0, 0, -1, 0);
        run_cmd(0, 32'h0000_000E, 5, 1, 0, -1, 0, 0, -1, 0);
        run_cmd(1, 32'h0000_0700, 2, 0, 0, 0, 0, 0, -1, 0);
        run_cmd(1, 32'h0000_0600, 3, 0, 0, -1, 0, 0, 1, 6);

        // asynchronous reset in the middle of an 8-beat write
        mon_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h200; cmd_len = 4'd7; cmd_bte = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            if (c > 0) @(negedge clk);
            wr_valid = 1'b1; wr_data = $urandom; wb.wb_ack_i = 1'b1;
            #1;
            if (wb.wb_stb_o) beats++;
        end
        @(posedge clk);
        #2;
        chk("rst_mid_stb_before", wb.wb_stb_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", wb.wb_cyc_o, 0);
        chk("rst_mid_stb", wb.wb_stb_o, 0);
        chk("rst_mid_done", done, 0);
        wb.wb_ack_i = 1'b0; wr_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1 chk("rst_mid_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_rel_cmd_ready", cmd_ready, 1);
        chk("rst_rel_cyc", wb.wb_cyc_o, 0);
        chk("rst_rel_done", done, 0);
        exp_beats.delete(); exp_rd.delete(); exp_done.delete();
        mon_en = 1'b1;

        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom % 2);
            adr = $urandom;
            if ($urandom % 8 == 0) adr = 32'hFFFF_FFC0 | 32'($urandom % 64);
            len = int'($urandom % 16);
            err_beat = ($urandom % 5 == 0) ? int'($urandom_range(0, len)) : -1;
            noack = ($urandom % 15 == 0);
            if (noack) err_beat = -1;
            run_cmd(we, adr, len, int'($urandom % 4), 1, err_beat, 1'($urandom % 2), noack, -1, 0);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", exp_beats.size() + exp_rd.size() + exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 Parameter DW, 32, Wishbone data width (only 32 supported).
REQ-002 Parameter AW, 32, Wishbone address width.
REQ-003 Parameter TIMEOUT, 255, max cycles with stb high and no ack/err/rty before abort; 0 disables the watchdog.
REQ-004 wb_clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i, cmd_ready_o  in/out  1  command handshake; the command is accepted when both are high on a clock edge.
REQ-007 cmd_we_i  in  1  write (1) or read (0) command.
REQ-008 cmd_adr_i  in  AW  start byte address, word aligned (bits [1:0] ignored, driven 0 on the bus).
REQ-009 cmd_len_i  in  4  beat count minus one (1..16 beats).
REQ-010 cmd_bte_i  in  2  burst type extension for the command.
REQ-011 wr_data_i, wr_valid_i, wr_ready_o  in/in/out  DW/1/1  write-data stream.
REQ-012 rd_data_o, rd_valid_o  out  DW/1  read-data stream; no backpressure.
REQ-013 done_o, done_err_o, done_beats_o  out  1/1/5  completion pulse, error flag and count of acked beats.
REQ-014 wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o  out  AW/DW/4/1/2/3/1/1  Wishbone B3 master outputs.
REQ-015 wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  in  DW/1/1/1  Wishbone B3 master inputs.

Function
REQ-016 The FSM SHALL have three states, IDLE, BUS and DONE; cmd_ready_o = (state==IDLE).
REQ-017 IDLE->BUS on command accept: latch we, len, bte; wb_adr_o=cmd_adr_i with [1:0]=0; beat counter=0; wb_cyc_o=1 on the next cycle.
REQ-018 In BUS: wb_cyc_o=1, wb_we_o=latched we, wb_bte_o=latched bte, wb_sel_o=4'hf.
REQ-019 wb_stb_o SHALL be combinational: BUS & (!we | wr_valid_i); with wr_valid_i low, stb drops for a wait state while cyc, adr and cti hold.
REQ-020 wb_dat_o = wr_data_i; wr_ready_o = wb_stb_o & we & wb_ack_i.
REQ-021 For len=0 wb_cti_o SHALL be 3'b000 (classic); for len>0 it SHALL be 3'b010 for beats 0..len-1 and 3'b111 for beat len, with the registered cti updated on the ack of beat len-1.
REQ-022 A beat completes on wb_ack_i & wb_stb_o: the counter increments and the word address advances per latched bte: 00 linear +4; 01 bits[3:2] wrap; 10 bits[4:2] wrap; 11 bits[5:2] wrap; the upper bits are unchanged in wrap modes.
REQ-023 Linear increment across bit AW-1 SHALL wrap modulo 2^AW with no error.
REQ-024 On a read beat: rd_data_o <= wb_dat_i and rd_valid_o=1 for exactly one cycle (the cycle after the ack).
REQ-025 On the ack of beat len: BUS->DONE; wb_cyc_o and wb_stb_o are 0 from the next cycle.
REQ-026 wb_err_i or wb_rty_i with stb high SHALL abort: BUS->DONE, err flag set, beat not counted, no rd_valid_o, no wr_ready_o.
REQ-027 The watchdog counter clears on every beat and on entering BUS, and increments while stb is high without ack/err/rty. When it reaches TIMEOUT (nonzero) it aborts like REQ-026. Cycles with stb low are not counted.
REQ-028 If ack and err are high simultaneously, err wins.
REQ-029 DONE SHALL last one cycle: done_o=1, done_err_o=err flag, done_beats_o=beats acked (0..16), then the FSM returns to IDLE; done_err_o and done_beats_o hold until the next DONE.
REQ-030 Inputs other than wr_data_i and wr_valid_i SHALL be ignored in IDLE and DONE; cmd_valid_i during BUS is not accepted.

Reset
REQ-031 Reset low SHALL asynchronously force IDLE and clear all of the following to 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_cti_o, wb_bte_o, rd_valid_o, rd_data_o, done_o, done_err_o, done_beats_o, the beat counter and the watchdog.
REQ-032 Reset asserted mid-burst SHALL drop cyc/stb immediately with no done_o; after deassertion the block is in IDLE with cmd_ready_o=1.

Verification
REQ-033 Read, adr=0x100, len=3, bte=00, slave acks every cycle -> adr 0x100,0x104,0x108,0x10C; cti 010,010,010,111; 4 rd_valid pulses; done_beats=4, done_err=0.
REQ-034 Write, adr=0x1C, len=7, bte=10, wr_valid low for 2 cycles at beat 3 -> stb low for 2 cycles; adr sequence 0x1C,0x00,0x04,...,0x18; 8 wr_ready pulses; done_beats=8.
REQ-035 Single read, len=0 -> cti=000, one rd_valid, done after 1 beat.
REQ-036 Read, len=15, err on beat 5 -> cyc low next cycle, done_err=1, done_beats=5, 5 rd_valid pulses.
REQ-037 TIMEOUT=4, read, slave never acks -> abort after 4 stb-high cycles, done_err=1, done_beats=0.
REQ-038 Reset asserted at beat 2 of an 8-beat write -> cyc/stb 0 asynchronously, no done_o, cmd_ready_o=1 after release.
